// File: rtl/prime_stream_monitor.sv
// Classifies a stream of 3-bit codes as prime and tracks total prime count,
// consecutive-prime run lengths and a run-length alert.
module prime_stream_monitor #(
  parameter int CNT_W      = 8,
  parameter int RUN_W      = 4,
  parameter int RUN_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             out_valid,
  output logic             is_prime,
  output logic [CNT_W-1:0] prime_count,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] max_run,
  output logic             alert,
  output logic             alert_pulse,
  output logic             cnt_sat
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ALERT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] THRESH  = RUN_W'(RUN_THRESH);

  logic [7:0]       prime_lut;
  logic             sample_prime;

  logic             out_valid_reg, out_valid_next;
  logic             is_prime_reg, is_prime_next;
  logic [CNT_W-1:0] prime_count_reg, prime_count_next;
  logic [RUN_W-1:0] run_len_reg, run_len_next;
  logic [RUN_W-1:0] max_run_reg, max_run_next;
  logic [1:0]       state_reg, state_next;
  logic             alert_pulse_reg, alert_pulse_next;
  logic             cnt_sat_reg, cnt_sat_next;

  // Constant table of the prime equation, one entry per possible code.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_prime_lut
      localparam logic [2:0] CODE = 3'(gi);
      assign prime_lut[gi] = (CODE[1] & ~CODE[2]) | (CODE[0] & CODE[2]);
    end
  endgenerate

  assign sample_prime = prime_lut[in_code];

  always_comb begin
    out_valid_next   = out_valid_reg;
    is_prime_next    = is_prime_reg;
    prime_count_next = prime_count_reg;
    run_len_next     = run_len_reg;
    max_run_next     = max_run_reg;
    state_next       = state_reg;
    alert_pulse_next = 1'b0;
    cnt_sat_next     = cnt_sat_reg;

    if (clear) begin
      out_valid_next   = 1'b0;
      is_prime_next    = 1'b0;
      prime_count_next = '0;
      run_len_next     = '0;
      max_run_next     = '0;
      state_next       = ST_IDLE;
      cnt_sat_next     = 1'b0;
    end else if (in_valid) begin
      out_valid_next = 1'b1;
      is_prime_next  = sample_prime;
      if (sample_prime) begin
        if (prime_count_reg == CNT_MAX) begin
          cnt_sat_next = 1'b1;
        end else begin
          prime_count_next = prime_count_reg + CNT_W'(1);
        end
        if (run_len_reg != RUN_MAX) begin
          run_len_next = run_len_reg + RUN_W'(1);
        end
        if (run_len_next > max_run_reg) begin
          max_run_next = run_len_next;
        end
        // From IDLE the new run length is 1, so a threshold of 1 alerts at once.
        case (state_reg)
          ST_IDLE, ST_RUN: begin
            if (run_len_next == THRESH) begin
              state_next       = ST_ALERT;
              alert_pulse_next = 1'b1;
            end else begin
              state_next = ST_RUN;
            end
          end
          ST_ALERT: state_next = ST_ALERT;
          default:  state_next = ST_IDLE;
        endcase
      end else begin
        run_len_next = '0;
        state_next   = ST_IDLE;
      end
    end else begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg   <= 1'b0;
      is_prime_reg    <= 1'b0;
      prime_count_reg <= '0;
      run_len_reg     <= '0;
      max_run_reg     <= '0;
      state_reg       <= ST_IDLE;
      alert_pulse_reg <= 1'b0;
      cnt_sat_reg     <= 1'b0;
    end else begin
      out_valid_reg   <= out_valid_next;
      is_prime_reg    <= is_prime_next;
      prime_count_reg <= prime_count_next;
      run_len_reg     <= run_len_next;
      max_run_reg     <= max_run_next;
      state_reg       <= state_next;
      alert_pulse_reg <= alert_pulse_next;
      cnt_sat_reg     <= cnt_sat_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign is_prime    = is_prime_reg;
  assign prime_count = prime_count_reg;
  assign run_len     = run_len_reg;
  assign max_run     = max_run_reg;
  assign alert       = (state_reg == ST_ALERT);
  assign alert_pulse = alert_pulse_reg;
  assign cnt_sat     = cnt_sat_reg;

endmodule
